// File: rtl/ascon_p_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ascon_p_sequencer_if                                          |
// | Purpose  : Job bus of the Ascon permutation round sequencer. It carries  |
// |            a 320-bit state plus a round count in, and the permuted       |
// |            state out. Each direction has its own valid/ready handshake.  |
// | Ports    : in_valid/in_ready/in_state/in_rounds   - job request         |
// |            out_valid/out_ready/out_state          - job result          |
// |            modport master : job producer / result consumer               |
// |            modport slave  : the sequencer                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ascon_p_sequencer_if #(
   parameter int BW = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [5*BW-1:0] in_state;
   logic [3:0]      in_rounds;
   logic            out_valid;
   logic            out_ready;
   logic [5*BW-1:0] out_state;

   modport master (
      output in_valid, in_state, in_rounds, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, in_rounds, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface
`default_nettype wire

// File: rtl/ascon_p_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ascon_p_sequencer                                             |
// | Purpose  : Round controller for the serial Ascon permutation core. Each  |
// |            round loads 5 words into the core, then reads 5 result words  |
// |            back into the work buffer. That takes 11 cycles per round.    |
// | Ports    : clk, rstn       - clock, synchronous active-low reset        |
// |            job (slave)     - job in / result out handshake bus          |
// |            busy            - job in progress                            |
// |            p_en            - core load enable (LOAD only)               |
// |            p_slice_idx     - core word index 0..4                       |
// |            p_round_const   - round constant, used by core at word 2     |
// |            p_slice_in      - word loaded into the core                  |
// |            p_slice_out     - core result word, 1 cycle after the index  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ascon_p_sequencer #(
   parameter int BW         = 64,
   parameter int ROUNDS_MAX = 12
) (
   input  logic                clk,
   input  logic                rstn,
   ascon_p_sequencer_if.slave  job,
   output logic                busy,
   output logic                p_en,
   output logic [2:0]          p_slice_idx,
   output logic [7:0]          p_round_const,
   output logic [BW-1:0]       p_slice_in,
   input  logic [BW-1:0]       p_slice_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [3:0] c_rounds_max = 4'(ROUNDS_MAX);
   localparam logic [2:0] c_last_word  = 3'd4;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_k;
   logic [2:0]      w_k_nxt;
   logic [3:0]      r_rnd;
   logic [3:0]      w_rnd_nxt;
   logic [3:0]      r_a;
   logic [BW-1:0]   r_work [5];
   logic            w_accept;
   logic [3:0]      w_a_sel;
   logic [3:0]      w_ci;

   assign w_accept = (r_state == IDLE) && job.in_valid;

   // Out-of-range counts fall back to the full permutation.
   assign w_a_sel = (job.in_rounds == 4'd0 || job.in_rounds > c_rounds_max)
                    ? c_rounds_max : job.in_rounds;

   // Constant index counts up so that the last round always uses index 11.
   assign w_ci = c_rounds_max - r_a + r_rnd;

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_rnd_nxt   = r_rnd;
      unique case (r_state)
         IDLE: begin
            if (job.in_valid) begin
               w_state_nxt = LOAD;
               w_k_nxt     = 3'd0;
               w_rnd_nxt   = 4'd0;
            end
         end
         LOAD: begin
            if (r_k == c_last_word) begin
               w_state_nxt = READ;
               w_k_nxt     = 3'd0;
            end else begin
               w_k_nxt = r_k + 3'd1;
            end
         end
         READ: begin
            if (r_k == c_last_word) begin
               w_state_nxt = DRAIN;
            end else begin
               w_k_nxt = r_k + 3'd1;
            end
         end
         DRAIN: begin
            if (r_rnd < r_a - 4'd1) begin
               w_state_nxt = LOAD;
               w_rnd_nxt   = r_rnd + 4'd1;
               w_k_nxt     = 3'd0;
            end else begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (job.out_ready) begin
               w_state_nxt = IDLE;
               w_k_nxt     = 3'd0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_k_nxt     = 3'd0;
         end
      endcase
   end

   // Counters and work buffer
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_k   <= 3'd0;
         r_rnd <= 4'd0;
         r_a   <= 4'd0;
         for (int i = 0; i < 5; i++) begin
            r_work[i] <= '0;
         end
      end else begin
         r_k   <= w_k_nxt;
         r_rnd <= w_rnd_nxt;
         if (w_accept) begin
            r_a <= w_a_sel;
            for (int i = 0; i < 5; i++) begin
               r_work[i] <= job.in_state[(4-i)*BW +: BW];
            end
         end
         // The core output lags the index by one cycle, so READ word k
         // delivers result word k-1 and DRAIN delivers the last word.
         if (r_state == READ && r_k != 3'd0) begin
            r_work[r_k - 3'd1] <= p_slice_out;
         end
         if (r_state == DRAIN) begin
            r_work[4] <= p_slice_out;
         end
      end
   end

   assign job.in_ready  = (r_state == IDLE);
   assign job.out_valid = (r_state == DONE);
   assign job.out_state = {r_work[0], r_work[1], r_work[2], r_work[3], r_work[4]};

   assign busy          = (r_state != IDLE);
   assign p_en          = (r_state == LOAD);
   assign p_slice_idx   = r_k;
   assign p_round_const = (r_state == LOAD) ? {~w_ci, w_ci} : 8'd0;
   assign p_slice_in    = (r_state == LOAD) ? r_work[r_k] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ascon_p_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ascon_p_sequencer                                          |
// | Purpose  : Self-checking bench for ascon_p_sequencer. It contains a      |
// |            behavioural serial core and a reference permutation. Expected |
// |            results are queued when a job starts and popped on output.    |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ascon_p_sequencer;

   logic          clk;
   logic          rstn;
   logic          busy;
   logic          p_en;
   logic [2:0]    p_slice_idx;
   logic [7:0]    p_round_const;
   logic [63:0]   p_slice_in;
   logic [63:0]   p_slice_out;

   int            n_tests;
   int            n_fail;

   logic [319:0]  sb_q[$];
   logic [7:0]    exp_c_q[$];
   logic [7:0]    obs_c_q[$];

   ascon_p_sequencer_if #(.BW(64)) job_if ();

   ascon_p_sequencer #(.BW(64), .ROUNDS_MAX(12)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .job           (job_if),
      .busy          (busy),
      .p_en          (p_en),
      .p_slice_idx   (p_slice_idx),
      .p_round_const (p_round_const),
      .p_slice_in    (p_slice_in),
      .p_slice_out   (p_slice_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One Ascon round: constant addition, substitution layer, linear layer.
   function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [4:0][63:0] o;
      x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = x0 ^ (~x1 & x2);
      t1 = x1 ^ (~x2 & x3);
      t2 = x2 ^ (~x3 & x4);
      t3 = x3 ^ (~x4 & x0);
      t4 = x4 ^ (~x0 & x1);
      t1 ^= t0; t0 ^= t4; t3 ^= t2; t2 = ~t2;
      o[0] = t0 ^ ror(t0, 19) ^ ror(t0, 28);
      o[1] = t1 ^ ror(t1, 61) ^ ror(t1, 39);
      o[2] = t2 ^ ror(t2, 1)  ^ ror(t2, 6);
      o[3] = t3 ^ ror(t3, 10) ^ ror(t3, 17);
      o[4] = t4 ^ ror(t4, 7)  ^ ror(t4, 41);
      return o;
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] st, input int a);
      logic [4:0][63:0] s;
      logic [319:0]     r;
      for (int j = 0; j < 5; j++) s[j] = st[(4-j)*64 +: 64];
      for (int rr = 0; rr < a; rr++) begin
         int i;
         i = 12 - a + rr;
         s = ascon_round(s, {4'(15 - i), 4'(i)});
      end
      for (int j = 0; j < 5; j++) r[(4-j)*64 +: 64] = s[j];
      return r;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] v;
      for (int j = 0; j < 10; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   // Behavioural serial core: the constant is injected when word 2 is loaded,
   // and the registered output is the round result for the indexed word.
   logic [4:0][63:0] core_s;
   logic [4:0][63:0] core_nx;
   assign core_nx = ascon_round(core_s, 8'h00);
   always @(posedge clk) begin
      if (p_en) begin
         core_s[p_slice_idx] <= (p_slice_idx == 3'd2) ? (p_slice_in ^ {56'd0, p_round_const})
                                                      : p_slice_in;
      end
      p_slice_out <= core_nx[p_slice_idx];
   end

   // Record the constant presented at each word-2 load.
   always @(negedge clk) begin
      if (rstn && p_en && p_slice_idx == 3'd2) obs_c_q.push_back(p_round_const);
   end

   // Starts a job from a negedge with the DUT idle and returns at the negedge
   // after the accept edge. Expected constants and result are queued here.
   task automatic start_job(input logic [319:0] st, input logic [3:0] rn);
      int a;
      a = (rn == 4'd0 || rn > 4'd12) ? 12 : int'(rn);
      exp_c_q.delete();
      obs_c_q.delete();
      for (int r = 0; r < a; r++) begin
         int i;
         i = 12 - a + r;
         exp_c_q.push_back({4'(15 - i), 4'(i)});
      end
      sb_q.push_back(ref_perm(st, a));
      job_if.in_state  = st;
      job_if.in_rounds = rn;
      job_if.in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      job_if.in_valid  = 1'b0;
   endtask

   // Counts cycles from the accept edge until out_valid is seen. For the
   // first 'noise' cycles it drives junk requests that must be ignored.
   task automatic wait_done(input int noise, output int cyc);
      cyc = 0;
      while (1) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (cyc < noise) begin
            job_if.in_valid  = 1'b1;
            job_if.in_state  = rand320();
            job_if.in_rounds = 4'd1;
         end else begin
            job_if.in_valid  = 1'b0;
         end
         if (job_if.out_valid === 1'b1 || cyc >= 300) break;
      end
      job_if.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (job_if.in_ready !== 1'b1 || job_if.out_valid !== 1'b0 || busy !== 1'b0 || p_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b p_en=%b, required 1 0 0 0",
                  job_if.in_ready, job_if.out_valid, busy, p_en);
      end
      n_tests++;
      if (job_if.out_state !== 320'd0 || p_slice_idx !== 3'd0 || p_round_const !== 8'd0 || p_slice_in !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_data: out_state=%h idx=%h const=%h slice_in=%h, required all zero",
                  job_if.out_state, p_slice_idx, p_round_const, p_slice_in);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_tests++;
      if (job_if.in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", job_if.in_ready, busy);
      end
   endtask

   task automatic test_rounds12();
      int cyc;
      logic [319:0] exp_s;
      logic [7:0] lit [12];
      lit = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
      job_if.out_ready = 1'b1;
      start_job(320'd0, 4'd12);
      wait_done(0, cyc);
      n_tests++;
      if (cyc !== 132) begin
         n_fail++;
         $display("FAIL r12_latency: got %0d cycles, required 132", cyc);
      end
      exp_s = sb_q.pop_front();
      n_tests++;
      if (job_if.out_state !== exp_s) begin
         n_fail++;
         $display("FAIL r12_state: got %h required %h", job_if.out_state, exp_s);
      end
      n_tests++;
      if (obs_c_q.size() != 12) begin
         n_fail++;
         $display("FAIL r12_const_count: got %0d required 12", obs_c_q.size());
      end else begin
         for (int j = 0; j < 12; j++) begin
            n_tests++;
            if (obs_c_q[j] !== lit[j]) begin
               n_fail++;
               $display("FAIL r12_const[%0d]: got %h required %h", j, obs_c_q[j], lit[j]);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (job_if.out_valid !== 1'b0 || job_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL r12_return_idle: out_valid=%b in_ready=%b, required 0 1",
                  job_if.out_valid, job_if.in_ready);
      end
   endtask

   task automatic test_rounds6();
      int cyc;
      logic [319:0] exp_s;
      logic [7:0] lit [6];
      lit = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
      job_if.out_ready = 1'b1;
      start_job(rand320(), 4'd6);
      wait_done(20, cyc);
      n_tests++;
      if (cyc !== 66) begin
         n_fail++;
         $display("FAIL r6_latency: got %0d cycles, required 66", cyc);
      end
      exp_s = sb_q.pop_front();
      n_tests++;
      if (job_if.out_state !== exp_s) begin
         n_fail++;
         $display("FAIL r6_state: got %h required %h", job_if.out_state, exp_s);
      end
      n_tests++;
      if (obs_c_q.size() != 6) begin
         n_fail++;
         $display("FAIL r6_const_count: got %0d required 6", obs_c_q.size());
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_tests++;
            if (obs_c_q[j] !== lit[j]) begin
               n_fail++;
               $display("FAIL r6_const[%0d]: got %h required %h", j, obs_c_q[j], lit[j]);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [319:0] exp_s;
      job_if.out_ready = 1'b0;
      start_job(rand320(), 4'd3);
      wait_done(0, cyc);
      n_tests++;
      if (cyc !== 33) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d cycles, required 33", cyc);
      end
      exp_s = sb_q.pop_front();
      n_tests++;
      if (job_if.out_state !== exp_s) begin
         n_fail++;
         $display("FAIL bp_state: got %h required %h", job_if.out_state, exp_s);
      end
      for (int j = 0; j < 10; j++) begin
         @(posedge clk);
         @(negedge clk);
         n_tests++;
         if (job_if.out_valid !== 1'b1 || job_if.in_ready !== 1'b0 || job_if.out_state !== exp_s) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b state=%h, required 1 0 %h",
                     j, job_if.out_valid, job_if.in_ready, job_if.out_state, exp_s);
         end
      end
      job_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (job_if.out_valid !== 1'b0 || job_if.in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                  job_if.out_valid, job_if.in_ready, busy);
      end
   endtask

   task automatic test_reset_midjob();
      int cyc;
      logic seen;
      logic [319:0] exp_s;
      job_if.out_ready = 1'b1;
      start_job(rand320(), 4'd12);
      void'(sb_q.pop_back());
      seen = 1'b0;
      // Accept edge + 29 edges puts the job in the READ phase of round 3.
      for (int j = 0; j < 29; j++) begin
         @(posedge clk);
         @(negedge clk);
         if (job_if.out_valid === 1'b1) seen = 1'b1;
      end
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || job_if.in_ready !== 1'b1 || job_if.out_valid !== 1'b0 || seen) begin
         n_fail++;
         $display("FAIL midreset_abort: busy=%b in_ready=%b out_valid=%b early_valid=%b, required 0 1 0 0",
                  busy, job_if.in_ready, job_if.out_valid, seen);
      end
      rstn = 1'b1;
      @(negedge clk);
      start_job(rand320(), 4'd8);
      wait_done(0, cyc);
      n_tests++;
      if (cyc !== 88) begin
         n_fail++;
         $display("FAIL midreset_r8_latency: got %0d cycles, required 88", cyc);
      end
      exp_s = sb_q.pop_front();
      n_tests++;
      if (job_if.out_state !== exp_s) begin
         n_fail++;
         $display("FAIL midreset_r8_state: got %h required %h", job_if.out_state, exp_s);
      end
      n_tests++;
      if (obs_c_q.size() != 8 || obs_c_q[0] !== exp_c_q[0] || obs_c_q[7] !== exp_c_q[7]) begin
         n_fail++;
         $display("FAIL midreset_r8_const: count=%0d, required 8 with first %h last %h",
                  obs_c_q.size(), exp_c_q[0], exp_c_q[7]);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_illegal_rounds();
      int cyc;
      logic [319:0] exp_s;
      logic [3:0] rn [2];
      rn = '{4'd0, 4'd15};
      job_if.out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         start_job(rand320(), rn[t]);
         wait_done(0, cyc);
         n_tests++;
         if (cyc !== 132) begin
            n_fail++;
            $display("FAIL illegal_%0d_latency: got %0d cycles, required 132", rn[t], cyc);
         end
         exp_s = sb_q.pop_front();
         n_tests++;
         if (job_if.out_state !== exp_s) begin
            n_fail++;
            $display("FAIL illegal_%0d_state: got %h required %h", rn[t], job_if.out_state, exp_s);
         end
         n_tests++;
         if (obs_c_q.size() != 12 || obs_c_q[0] !== 8'hF0) begin
            n_fail++;
            $display("FAIL illegal_%0d_const: count=%0d first=%h, required 12 F0",
                     rn[t], obs_c_q.size(), (obs_c_q.size() > 0) ? obs_c_q[0] : 8'hxx);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      rstn             = 1'b0;
      job_if.in_valid  = 1'b0;
      job_if.in_state  = '0;
      job_if.in_rounds = 4'd0;
      job_if.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_rounds12();
      test_rounds6();
      test_backpressure();
      test_reset_midjob();
      test_illegal_rounds();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
